// File: rtl/trans_axi_resp.sv
// AXI4 responder backing a 128-bit entry store, with independent read and write FSMs.
// Define TRANS_RESP_STALL_EN to add LFSR-driven backpressure on arready/awready/wready/rvalid.
module trans_axi_resp #(
    parameter int unsigned ADDR_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  trans_axi_araddr,
    input  logic [1:0]   trans_axi_arburst,
    input  logic [7:0]   trans_axi_arlen,
    input  logic [2:0]   trans_axi_arsize,
    input  logic         trans_axi_arvalid,
    output logic         trans_axi_arready,
    output logic [127:0] trans_axi_rdata,
    output logic [1:0]   trans_axi_rresp,
    output logic         trans_axi_rlast,
    output logic         trans_axi_rvalid,
    input  logic         trans_axi_rready,
    input  logic [31:0]  trans_axi_awaddr,
    input  logic [1:0]   trans_axi_awburst,
    input  logic [7:0]   trans_axi_awlen,
    input  logic [2:0]   trans_axi_awsize,
    input  logic         trans_axi_awvalid,
    output logic         trans_axi_awready,
    input  logic [127:0] trans_axi_wdata,
    input  logic [15:0]  trans_axi_wstrb,
    input  logic         trans_axi_wlast,
    input  logic         trans_axi_wvalid,
    output logic         trans_axi_wready,
    output logic [1:0]   trans_axi_bresp,
    output logic         trans_axi_bvalid,
    input  logic         trans_axi_bready,
    output logic         protocol_error_out
);
    localparam int unsigned Depth = 1 << ADDR_LOG2;
    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [2:0] SizeBeat = 3'd4;
    localparam logic [1:0] RespOkay = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    logic [127:0] mem [Depth];

    r_state_e     r_state_q, r_state_d;
    logic [28:0]  r_off_q, r_off_d;
    logic         r_below_q, r_below_d;
    logic [7:0]   r_len_q, r_len_d;
    logic [7:0]   r_cnt_q, r_cnt_d;
    logic         r_bad_q, r_bad_d;
    logic [127:0] rdata_q;
    logic [1:0]   rresp_q;

    w_state_e     w_state_q, w_state_d;
    logic [28:0]  w_off_q, w_off_d;
    logic         w_below_q, w_below_d;
    logic [7:0]   w_len_q, w_len_d;
    logic [7:0]   w_cnt_q, w_cnt_d;
    logic         w_bad_q, w_bad_d;
    logic         w_err_q, w_err_d;
    logic         perr_q, perr_d;

    logic gate_ar, gate_aw, gate_w, gate_r;
    logic ar_hs, r_hs, aw_hs, w_hs;
    logic ar_bad, aw_bad, r_inr, w_inr, mem_we;
    logic [28:0] ar_off, aw_off;
    logic ar_below, aw_below;
    logic [ADDR_LOG2-1:0] r_idx, w_idx;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{trans_axi_araddr[3:0], trans_axi_awaddr[3:0]};

`ifdef TRANS_RESP_STALL_EN
    logic [15:0] lfsr_q;
    logic        rv_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q    <= 16'hACE1;
            rv_hold_q <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            rv_hold_q <= trans_axi_rvalid & ~trans_axi_rready;
        end
    end

    assign gate_ar = lfsr_q[0];
    assign gate_aw = lfsr_q[5];
    assign gate_w  = lfsr_q[10];
    // Once offered, rvalid must persist until accepted.
    assign gate_r  = lfsr_q[15] | rv_hold_q;
`else
    assign gate_ar = 1'b1;
    assign gate_aw = 1'b1;
    assign gate_w  = 1'b1;
    assign gate_r  = 1'b1;
`endif

    // Offsets are kept wider than the index so a burst running past the top stays out of range.
    assign ar_off   = {1'b0, trans_axi_araddr[31:4]} - {1'b0, BASE_ADDR[31:4]};
    assign aw_off   = {1'b0, trans_axi_awaddr[31:4]} - {1'b0, BASE_ADDR[31:4]};
    assign ar_below = trans_axi_araddr[31:4] < BASE_ADDR[31:4];
    assign aw_below = trans_axi_awaddr[31:4] < BASE_ADDR[31:4];
    assign ar_bad   = (trans_axi_arsize != SizeBeat) || (trans_axi_arburst != BurstIncr);
    assign aw_bad   = (trans_axi_awsize != SizeBeat) || (trans_axi_awburst != BurstIncr);

    assign r_idx = r_off_q[ADDR_LOG2-1:0];
    assign w_idx = w_off_q[ADDR_LOG2-1:0];
    assign r_inr = !r_below_q && (r_off_q < 29'(Depth));
    assign w_inr = !w_below_q && (w_off_q < 29'(Depth));

    assign trans_axi_arready  = (r_state_q == RIdle) && gate_ar && !reset;
    assign trans_axi_rvalid   = (r_state_q == RData) && gate_r && !reset;
    assign trans_axi_rlast    = (r_state_q == RData) && (r_cnt_q == r_len_q) && !reset;
    assign trans_axi_rdata    = rdata_q;
    assign trans_axi_rresp    = rresp_q;
    assign trans_axi_awready  = (w_state_q == WIdle) && gate_aw && !reset;
    assign trans_axi_wready   = (w_state_q == WData) && gate_w && !reset;
    assign trans_axi_bvalid   = (w_state_q == WResp) && !reset;
    assign trans_axi_bresp    = (w_state_q == WResp && w_err_q) ? RespSlverr : RespOkay;
    assign protocol_error_out = perr_q;

    assign ar_hs  = trans_axi_arvalid && trans_axi_arready;
    assign r_hs   = trans_axi_rvalid && trans_axi_rready;
    assign aw_hs  = trans_axi_awvalid && trans_axi_awready;
    assign w_hs   = trans_axi_wvalid && trans_axi_wready;
    assign mem_we = w_hs && w_inr && !w_bad_q;

    always_comb begin
        r_state_d = r_state_q;
        r_off_d   = r_off_q;
        r_below_d = r_below_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        unique case (r_state_q)
            RIdle: begin
                if (ar_hs) begin
                    r_off_d   = ar_off;
                    r_below_d = ar_below;
                    r_len_d   = trans_axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_bad_d   = ar_bad;
                    r_state_d = RFetch;
                end
            end
            RFetch: r_state_d = RData;
            RData: begin
                if (r_hs) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = RIdle;
                    end else begin
                        r_off_d   = r_off_q + 29'd1;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = RFetch;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_off_d   = w_off_q;
        w_below_d = w_below_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        unique case (w_state_q)
            WIdle: begin
                if (aw_hs) begin
                    w_off_d   = aw_off;
                    w_below_d = aw_below;
                    w_len_d   = trans_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_bad_d   = aw_bad;
                    w_err_d   = aw_bad;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (w_hs) begin
                    if (!w_inr) w_err_d = 1'b1;
                    w_off_d = w_off_q + 29'd1;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) w_state_d = WResp;
                end
            end
            WResp: if (trans_axi_bready) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    // Beat count, not wlast, decides the end of a write burst; wlast only feeds the error flag.
    always_comb begin
        perr_d = perr_q;
        if (ar_hs && ar_bad) perr_d = 1'b1;
        if (aw_hs && aw_bad) perr_d = 1'b1;
        if (w_hs && (trans_axi_wlast != (w_cnt_q == w_len_q))) perr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= RIdle;
            r_off_q   <= '0;
            r_below_q <= 1'b0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_bad_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            w_state_q <= WIdle;
            w_off_q   <= '0;
            w_below_q <= 1'b0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_off_q   <= r_off_d;
            r_below_q <= r_below_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_bad_q   <= r_bad_d;
            w_state_q <= w_state_d;
            w_off_q   <= w_off_d;
            w_below_q <= w_below_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            perr_q    <= perr_d;
            if (r_state_q == RFetch) begin
                rdata_q <= r_inr ? mem[r_idx] : '0;
                rresp_q <= (r_inr && !r_bad_q) ? RespOkay : RespSlverr;
            end
        end
    end

    // Non-blocking update keeps a same-cycle fetch of this entry read-first.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (trans_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= trans_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_trans_axi_resp.sv
// Self-checking bench for trans_axi_resp: directed scenarios plus a randomized
// read/write mix checked against a byte-level shadow memory.
`timescale 1ns/1ps
module tb_trans_axi_resp;
    localparam int unsigned Depth = 1024;
    localparam int Budget = 200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  araddr = '0;
    logic [1:0]   arburst = 2'b01;
    logic [7:0]   arlen = '0;
    logic [2:0]   arsize = 3'd4;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [31:0]  awaddr = '0;
    logic [1:0]   awburst = 2'b01;
    logic [7:0]   awlen = '0;
    logic [2:0]   awsize = 3'd4;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wlast = 1'b0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic         protocol_error_out;

    always #5 clk = ~clk;

    trans_axi_resp dut (
        .clk(clk), .reset(reset),
        .trans_axi_araddr(araddr), .trans_axi_arburst(arburst), .trans_axi_arlen(arlen),
        .trans_axi_arsize(arsize), .trans_axi_arvalid(arvalid), .trans_axi_arready(arready),
        .trans_axi_rdata(rdata), .trans_axi_rresp(rresp), .trans_axi_rlast(rlast),
        .trans_axi_rvalid(rvalid), .trans_axi_rready(rready),
        .trans_axi_awaddr(awaddr), .trans_axi_awburst(awburst), .trans_axi_awlen(awlen),
        .trans_axi_awsize(awsize), .trans_axi_awvalid(awvalid), .trans_axi_awready(awready),
        .trans_axi_wdata(wdata), .trans_axi_wstrb(wstrb), .trans_axi_wlast(wlast),
        .trans_axi_wvalid(wvalid), .trans_axi_wready(wready),
        .trans_axi_bresp(bresp), .trans_axi_bvalid(bvalid), .trans_axi_bready(bready),
        .protocol_error_out(protocol_error_out)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [127:0] model_mem [Depth];
    logic [127:0] wr_data[$];
    logic [15:0]  wr_strb[$];
    logic [127:0] rd_data[$];
    logic [1:0]   rd_resp[$];
    logic         rd_last[$];
    int           rd_first_lat;
    int           rd_unstable;
    bit           rd_timeout;
    logic [1:0]   wr_resp;
    bit           wr_timeout;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] exp_data(input logic [31:0] addr, input int beat);
        int unsigned idx = int'(addr >> 4) + beat;
        return (idx < Depth) ? model_mem[idx] : 128'd0;
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] addr, input int beat,
                                             input bit attr_ok);
        int unsigned idx = int'(addr >> 4) + beat;
        return (idx < Depth && attr_ok) ? 2'b00 : 2'b10;
    endfunction

    // Applies the queued write beats to the shadow memory and yields the expected bresp.
    task automatic model_write(input logic [31:0] addr, input int len, input bit attr_ok,
                               output logic [1:0] resp);
        resp = attr_ok ? 2'b00 : 2'b10;
        for (int i = 0; i <= len; i++) begin
            int unsigned idx = int'(addr >> 4) + i;
            if (idx >= Depth) resp = 2'b10;
            else if (attr_ok)
                for (int b = 0; b < 16; b++)
                    if (wr_strb[i][b]) model_mem[idx][8*b +: 8] = wr_data[i][8*b +: 8];
        end
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, output bit ok);
        int n = 0;
        @(negedge clk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < Budget) begin @(negedge clk); n++; end
        ok = arready;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, output bit ok);
        int n = 0;
        @(negedge clk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < Budget) begin @(negedge clk); n++; end
        ok = awready;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_beat, input int stall_cycles);
        bit ok;
        int cyc = 1;
        int beat = 0;
        int stalled = 0;
        logic [130:0] snap = '0;
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        rd_first_lat = -1; rd_unstable = 0; rd_timeout = 1'b0;
        do_ar(addr, 8'(len), size, burst, ok);
        if (!ok) begin rd_timeout = 1'b1; return; end
        while (beat <= len && cyc < Budget) begin
            if (rvalid) begin
                if (beat == 0 && rd_first_lat < 0) rd_first_lat = cyc;
                if (beat == stall_beat && stalled < stall_cycles) begin
                    if (stalled == 0) snap = {rdata, rresp, rlast};
                    else if ({rdata, rresp, rlast} !== snap) rd_unstable++;
                    stalled++;
                    rready = 1'b0;
                end else begin
                    if (beat == stall_beat && stalled > 0 && {rdata, rresp, rlast} !== snap)
                        rd_unstable++;
                    rready = 1'b1;
                    rd_data.push_back(rdata); rd_resp.push_back(rresp); rd_last.push_back(rlast);
                    beat++;
                end
            end else begin
                rready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (beat <= len) rd_timeout = 1'b1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int bad_last_beat);
        bit ok;
        int n;
        wr_timeout = 1'b0;
        wr_resp = 2'bxx;
        do_aw(addr, 8'(len), size, burst, ok);
        if (!ok) begin wr_timeout = 1'b1; return; end
        for (int beat = 0; beat <= len; beat++) begin
            wdata = wr_data[beat]; wstrb = wr_strb[beat];
            wlast = (beat == len) ^ (beat == bad_last_beat);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < Budget) begin @(negedge clk); n++; end
            if (!wready) wr_timeout = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < Budget) begin @(negedge clk); n++; end
        if (!bvalid) wr_timeout = 1'b1;
        wr_resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (64) @(negedge clk);
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes_in_reset: got %b required 00000",
                     {arready, awready, wready, rvalid, bvalid});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_idle_handshakes: got %b required 11000",
                     {arready, awready, wready, rvalid, bvalid});
        end
        n_checks++;
        if ({rdata, rresp, rlast, bresp, protocol_error_out} !== 134'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata %h rresp %b rlast %b bresp %b perr %b required 0",
                     rdata, rresp, rlast, bresp, protocol_error_out);
        end
    endtask

    task automatic test_single();
        logic [1:0] eb;
        wr_data = {128'h0123456789ABCDEF0123456789ABCDEF}; wr_strb = {16'hFFFF};
        model_write(32'h100, 0, 1'b1, eb);
        axi_write(32'h100, 0, 3'd4, 2'b01, -1);
        n_checks++;
        if (wr_timeout || wr_resp !== eb) begin
            n_fail++;
            $display("FAIL single_bresp: got %b (timeout %0d) required %b", wr_resp, wr_timeout, eb);
        end
        axi_read(32'h100, 0, 3'd4, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_first_lat != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d (timeout %0d) required 2", rd_first_lat, rd_timeout);
        end
        n_checks++;
        if (rd_data.size() != 1 || rd_data[0] !== 128'h0123456789ABCDEF0123456789ABCDEF ||
            rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL single_readback: beats %0d data %h last %b resp %b required 1 %h 1 00",
                     rd_data.size(), rd_data[0], rd_last[0], rd_resp[0],
                     128'h0123456789ABCDEF0123456789ABCDEF);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] eb;
        wr_data = {128'd0}; wr_strb = {16'hFFFF};
        model_write(32'h200, 0, 1'b1, eb);
        axi_write(32'h200, 0, 3'd4, 2'b01, -1);
        wr_data = {{128{1'b1}}}; wr_strb = {16'h000F};
        model_write(32'h200, 0, 1'b1, eb);
        axi_write(32'h200, 0, 3'd4, 2'b01, -1);
        axi_read(32'h200, 0, 3'd4, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_data.size() != 1 || rd_data[0] !== 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL strobe_readback: got %h required %h", rd_data[0],
                     128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        end
    endtask

    task automatic test_burst_stall();
        logic [1:0] eb;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 4; i++) begin wr_data.push_back(rand128()); wr_strb.push_back(16'hFFFF); end
        model_write(32'h40, 3, 1'b1, eb);
        axi_write(32'h40, 3, 3'd4, 2'b01, -1);
        n_checks++;
        if (wr_timeout || wr_resp !== eb) begin
            n_fail++;
            $display("FAIL burst_bresp: got %b required %b", wr_resp, eb);
        end
        axi_read(32'h40, 3, 3'd4, 2'b01, 2, 5);
        n_checks++;
        if (rd_timeout || rd_data.size() != 4) begin
            n_fail++;
            $display("FAIL burst_beats: got %0d required 4", rd_data.size());
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            n_checks++;
            if (rd_data[i] !== exp_data(32'h40, i) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL burst_beat%0d: data %h last %b resp %b required %h %b 00",
                         i, rd_data[i], rd_last[i], rd_resp[i], exp_data(32'h40, i), i == 3);
            end
        end
        n_checks++;
        if (rd_unstable != 0) begin
            n_fail++;
            $display("FAIL burst_stall_stable: got %0d changes required 0", rd_unstable);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] eb;
        wr_data = {rand128()}; wr_strb = {16'hFFFF};
        model_write(32'h0, 0, 1'b1, eb);
        axi_write(32'h0, 0, 3'd4, 2'b01, -1);
        axi_read(32'h4000, 0, 3'd4, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_resp[0] !== 2'b10 || rd_data[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL oor_read: resp %b data %h required 10 0", rd_resp[0], rd_data[0]);
        end
        wr_data = {{128{1'b1}}}; wr_strb = {16'hFFFF};
        model_write(32'h4000, 0, 1'b1, eb);
        axi_write(32'h4000, 0, 3'd4, 2'b01, -1);
        n_checks++;
        if (wr_timeout || wr_resp !== 2'b10) begin
            n_fail++;
            $display("FAIL oor_bresp: got %b required 10", wr_resp);
        end
        axi_read(32'h0, 0, 3'd4, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_data[0] !== model_mem[0]) begin
            n_fail++;
            $display("FAIL oor_mem_unchanged: got %h required %h", rd_data[0], model_mem[0]);
        end
        // Burst crossing the top of the store.
        wr_data = {rand128(), rand128()}; wr_strb = {16'hFFFF, 16'hFFFF};
        model_write(32'h3FE0, 1, 1'b1, eb);
        axi_write(32'h3FE0, 1, 3'd4, 2'b01, -1);
        axi_read(32'h3FE0, 3, 3'd4, 2'b01, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_timeout || rd_data.size() != 4 || rd_data[i] !== exp_data(32'h3FE0, i) ||
                rd_resp[i] !== exp_rresp(32'h3FE0, i, 1'b1)) begin
                n_fail++;
                $display("FAIL cross_top_beat%0d: data %h resp %b required %h %b", i, rd_data[i],
                         rd_resp[i], exp_data(32'h3FE0, i), exp_rresp(32'h3FE0, i, 1'b1));
            end
        end
        n_checks++;
        if (protocol_error_out !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clean: got %b required 0", protocol_error_out);
        end
    endtask

    task automatic test_wlast_error();
        logic [1:0] eb;
        wr_data = {rand128(), rand128()}; wr_strb = {16'hFFFF, 16'hFFFF};
        model_write(32'h300, 1, 1'b1, eb);
        axi_write(32'h300, 1, 3'd4, 2'b01, 0);
        n_checks++;
        if (wr_timeout || wr_resp !== eb) begin
            n_fail++;
            $display("FAIL wlast_bresp: got %b (timeout %0d) required %b", wr_resp, wr_timeout, eb);
        end
        n_checks++;
        if (protocol_error_out !== 1'b1) begin
            n_fail++;
            $display("FAIL wlast_perr: got %b required 1", protocol_error_out);
        end
        axi_read(32'h300, 1, 3'd4, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_data.size() != 2 || rd_data[0] !== model_mem[48] ||
            rd_data[1] !== model_mem[49]) begin
            n_fail++;
            $display("FAIL wlast_both_beats: got %h %h required %h %h", rd_data[0], rd_data[1],
                     model_mem[48], model_mem[49]);
        end
        n_checks++;
        if (protocol_error_out !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_sticky: got %b required 1", protocol_error_out);
        end
    endtask

    task automatic test_bad_attr();
        axi_read(32'h100, 1, 3'd3, 2'b01, -1, 0);
        n_checks++;
        if (rd_timeout || rd_data.size() != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 ||
            rd_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_size_read: beats %0d resp %b %b required 2 10 10", rd_data.size(),
                     rd_resp[0], rd_resp[1]);
        end
        wr_data = {rand128()}; wr_strb = {16'hFFFF};
        axi_write(32'h100, 0, 3'd4, 2'b10, -1);
        n_checks++;
        if (wr_timeout || wr_resp !== 2'b10) begin
            n_fail++;
            $display("FAIL bad_burst_bresp: got %b required 10", wr_resp);
        end
    endtask

    task automatic test_random();
        logic [1:0] eb;
        for (int blk = 0; blk < 8; blk++) begin
            logic [31:0] a = 32'h2000 + 32'(blk * 128);
            wr_data.delete(); wr_strb.delete();
            for (int i = 0; i < 8; i++) begin wr_data.push_back(rand128()); wr_strb.push_back(16'hFFFF); end
            model_write(a, 7, 1'b1, eb);
            axi_write(a, 7, 3'd4, 2'b01, -1);
        end
        for (int op = 0; op < 30; op++) begin
            int len = $urandom_range(0, 3);
            int idx = $urandom_range(512, 575 - len);
            logic [31:0] a = 32'(idx * 16) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wr_data.delete(); wr_strb.delete();
                for (int i = 0; i <= len; i++) begin
                    wr_data.push_back(rand128()); wr_strb.push_back(16'($urandom));
                end
                model_write(a, len, 1'b1, eb);
                axi_write(a, len, 3'd4, 2'b01, -1);
                n_checks++;
                if (wr_timeout || wr_resp !== eb) begin
                    n_fail++;
                    $display("FAIL rand_bresp op%0d: got %b required %b", op, wr_resp, eb);
                end
            end else begin
                axi_read(a, len, 3'd4, 2'b01, -1, 0);
                n_checks++;
                if (rd_timeout || rd_data.size() != len + 1) begin
                    n_fail++;
                    $display("FAIL rand_beats op%0d: got %0d required %0d", op, rd_data.size(), len + 1);
                end
                for (int i = 0; i < rd_data.size(); i++) begin
                    n_checks++;
                    if (rd_data[i] !== exp_data(a, i) || rd_last[i] !== (i == len) ||
                        rd_resp[i] !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rand_read op%0d beat%0d: data %h last %b resp %b required %h",
                                 op, i, rd_data[i], rd_last[i], rd_resp[i], exp_data(a, i));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int n = 0;
        do_ar(32'h40, 8'd3, 3'd4, 2'b01, ok);
        while (!rvalid && n < Budget) begin @(negedge clk); n++; end
        n_checks++;
        if (!ok || !rvalid) begin
            n_fail++;
            $display("FAIL midburst_reach_rdata: got rvalid %b required 1", rvalid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_rvalid_drop: rvalid %b bvalid %b required 0 0", rvalid, bvalid);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (arready !== 1'b1 || protocol_error_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_recover: arready %b perr %b required 1 0", arready, protocol_error_out);
        end
        axi_read(32'h40, 3, 3'd4, 2'b01, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_timeout || rd_data.size() != 4 || rd_data[i] !== exp_data(32'h40, i)) begin
                n_fail++;
                $display("FAIL midburst_mem_kept beat%0d: got %h required %h", i, rd_data[i],
                         exp_data(32'h40, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_burst_stall();
        test_out_of_range();
        test_random();
        test_wlast_error();
        test_bad_attr();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
